// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: byte stream to GMII TX bus {en, er, data} with preamble/SFD, padding, CRC-32 FCS, IPG and abort.
// Define GMII_TX_FRAMER_STATS_EN to build the frames_sent / frames_aborted counters; otherwise they read 0.
module gmii_tx_framer #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IPG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up,
  input  logic        frame_valid,
  input  logic        frame_start,
  input  logic        frame_last,
  input  logic [7:0]  frame_data,
  output logic        frame_ready,
  output logic [9:0]  gmii_tx_bus,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [31:0] frames_aborted
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, ABORT, IPG} state_t;
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [7:0] IPG_LAST = 8'(IPG_CYCLES - 1);
  state_t state, state_d;
  logic [7:0] cnt, cnt_d, held, held_d;
  logic [15:0] len, len_d, len_inc;
  logic [31:0] crc, crc_d;
  logic held_last, held_last_d, ready_d, sent_inc, abort_inc;
  logic [9:0] bus_d;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  assign len_inc = (len == 16'hFFFF) ? len : len + 16'd1;
  // bus_d/ready_d describe the next cycle, so every output leaves a flop
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    len_d = len;
    crc_d = crc;
    held_d = held;
    held_last_d = held_last;
    bus_d = 10'h000;
    ready_d = 1'b0;
    sent_inc = 1'b0;
    abort_inc = 1'b0;
    if (state inside {PREAMBLE, DATA, PAD, FCS} && !link_up) begin
      state_d = ABORT;
      bus_d = 10'h300;
    end else begin
      case (state)
        IDLE: begin
          ready_d = link_up;
          if (frame_valid && frame_ready && frame_start) begin
            state_d = PREAMBLE;
            cnt_d = 8'd0;
            held_d = frame_data;
            held_last_d = frame_last;
            crc_d = 32'hFFFFFFFF;
            len_d = 16'd0;
            bus_d = 10'h255;
            ready_d = 1'b0;
          end
        end
        PREAMBLE: begin
          cnt_d = cnt + 8'd1;
          bus_d = (cnt == 8'd6) ? 10'h2D5 : 10'h255;
          if (cnt == 8'd7) begin
            state_d = DATA;
            bus_d = {2'b10, held};
            ready_d = !held_last;
          end
        end
        DATA: begin
          crc_d = crc_byte(crc, held);
          len_d = len_inc;
          if (held_last) begin
            state_d = (len_inc < MIN_LEN) ? PAD : FCS;
            cnt_d = 8'd0;
            bus_d = (len_inc < MIN_LEN) ? 10'h200 : {2'b10, ~crc_d[7:0]};
          end else if (!frame_valid) begin
            state_d = ABORT;
            bus_d = 10'h300;
          end else begin
            held_d = frame_data;
            held_last_d = frame_last;
            bus_d = {2'b10, frame_data};
            ready_d = !frame_last;
          end
        end
        PAD: begin
          crc_d = crc_byte(crc, 8'h00);
          len_d = len_inc;
          state_d = (len_inc >= MIN_LEN) ? FCS : PAD;
          cnt_d = 8'd0;
          bus_d = (len_inc >= MIN_LEN) ? {2'b10, ~crc_d[7:0]} : 10'h200;
        end
        FCS: begin
          // crc shifts down a byte per cycle so the next FCS byte is always crc_d[7:0]
          cnt_d = cnt + 8'd1;
          crc_d = {8'hFF, crc[31:8]};
          bus_d = {2'b10, ~crc_d[7:0]};
          if (cnt == 8'd3) begin
            state_d = IPG;
            cnt_d = 8'd0;
            bus_d = 10'h000;
            sent_inc = 1'b1;
          end
        end
        ABORT: begin
          state_d = IPG;
          cnt_d = 8'd0;
          abort_inc = 1'b1;
        end
        IPG: begin
          cnt_d = cnt + 8'd1;
          if (cnt == IPG_LAST) begin
            state_d = IDLE;
            ready_d = link_up;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      crc <= '0;
      held <= '0;
      held_last <= 1'b0;
      gmii_tx_bus <= '0;
      frame_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      len <= len_d;
      crc <= crc_d;
      held <= held_d;
      held_last <= held_last_d;
      gmii_tx_bus <= bus_d;
      frame_ready <= ready_d;
      busy <= state_d != IDLE;
    end
`ifdef GMII_TX_FRAMER_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frames_sent <= '0;
      frames_aborted <= '0;
    end else begin
      if (sent_inc) frames_sent <= frames_sent + 32'd1;
      if (abort_inc) frames_aborted <= frames_aborted + 32'd1;
    end
`else
  logic unused_stats;
  assign unused_stats = sent_inc | abort_inc;
  assign frames_sent = 32'h0;
  assign frames_aborted = 32'h0;
`endif
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed checks of gmii_tx_framer; u_crc (no padding) for the CRC frame, u_dut (MIN 60) for the rest.
module tb_gmii_tx_framer;
`ifdef GMII_TX_FRAMER_STATS_EN
  localparam logic [31:0] STATS = 32'd1;
`else
  localparam logic [31:0] STATS = 32'd0;
`endif
  logic clk = 1'b0;
  always #4 clk = ~clk;
  logic rst_n, link_up, fv, fs, fl, sel;
  logic [7:0] fd;
  logic rdy0, rdy1, busy0, busy1, rdy, busy_s;
  logic [9:0] bus0, bus1, bus;
  logic [31:0] sent0, ab0, sent1, ab1, sent, ab;
  int checks = 0, errors = 0, er_cnt = 0;
  int base, er0, gap, t, ok;
  logic [9:0] txq[$];
  logic [9:0] exp_q[$];
  logic [7:0] frm[$];
  logic [31:0] fcs;
  gmii_tx_framer #(.MIN_FRAME_LEN(0), .IPG_CYCLES(12)) u_crc (
    .clk(clk), .rst_n(rst_n), .link_up(link_up), .frame_valid(fv & !sel), .frame_start(fs),
    .frame_last(fl), .frame_data(fd), .frame_ready(rdy0), .gmii_tx_bus(bus0), .busy(busy0),
    .frames_sent(sent0), .frames_aborted(ab0));
  gmii_tx_framer #(.MIN_FRAME_LEN(60), .IPG_CYCLES(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .link_up(link_up), .frame_valid(fv & sel), .frame_start(fs),
    .frame_last(fl), .frame_data(fd), .frame_ready(rdy1), .gmii_tx_bus(bus1), .busy(busy1),
    .frames_sent(sent1), .frames_aborted(ab1));
  assign rdy = sel ? rdy1 : rdy0;
  assign busy_s = sel ? busy1 : busy0;
  assign bus = sel ? bus1 : bus0;
  assign sent = sel ? sent1 : sent0;
  assign ab = sel ? ab1 : ab0;
  always @(negedge clk)
    if (bus[9]) begin
      txq.push_back(bus);
      if (bus[8]) er_cnt++;
    end
  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int j = 0; j < 8; j++) c = (c[0] ^ b[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] d, input logic s, input logic l);
    int n;
    n = 0;
    fv = 1'b1;
    fd = d;
    fs = s;
    fl = l;
    while (!rdy && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(n < 100), 32'd1);
    tick();
  endtask
  task automatic wait_idle(output int g);
    int n;
    g = 0;
    n = 0;
    while (busy_s && n < 400) begin
      if (!bus[9]) g++;
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 400), 32'd1);
  endtask
  initial begin
    rst_n = 1'b0; link_up = 1'b1; fv = 1'b0; fs = 1'b0; fl = 1'b0; fd = 8'h00; sel = 1'b1;
    repeat (3) tick();
    check("rst_bus", 32'(bus1), 32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_ready", 32'(rdy1), 32'h0);
    check("rst_sent", sent1, 32'h0);
    check("rst_aborted", ab1, 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(rdy1), 32'h1);
    // CRC frame "123456789" without padding
    sel = 1'b0;
    tick();
    base = txq.size();
    for (int i = 0; i < 9; i++) send_byte(8'(32'h31 + i), i == 0, i == 8);
    fv = 1'b0;
    wait_idle(gap);
    exp_q = {10'h255, 10'h255, 10'h255, 10'h255, 10'h255, 10'h255, 10'h255, 10'h2D5,
             10'h231, 10'h232, 10'h233, 10'h234, 10'h235, 10'h236, 10'h237, 10'h238, 10'h239,
             10'h226, 10'h239, 10'h2F4, 10'h2CB};
    check("crc_en_cycles", txq.size() - base, 32'd21);
    for (int i = 0; i < 21; i++) check("crc_frame_byte", 32'(txq[base + i]), 32'(exp_q[i]));
    check("crc_gap", gap, 32'd12);
    check("crc_sent", sent0, STATS);
    // single byte padded to 60
    sel = 1'b1;
    tick();
    base = txq.size();
    er0 = er_cnt;
    send_byte(8'hAB, 1'b1, 1'b1);
    fv = 1'b0;
    wait_idle(gap);
    check("pad_en_cycles", txq.size() - base, 32'd72);
    check("pad_er", er_cnt - er0, 32'd0);
    check("pad_gap", gap, 32'd12);
    check("pad_sfd", 32'(txq[base + 7]), 32'h2D5);
    check("pad_data", 32'(txq[base + 8]), 32'h2AB);
    ok = 1;
    for (int i = 9; i < 68; i++) if (txq[base + i] !== 10'h200) ok = 0;
    check("pad_zeros", ok, 32'd1);
    frm = {8'hAB};
    for (int i = 0; i < 59; i++) frm.push_back(8'h00);
    fcs = crc_model(frm);
    for (int k = 0; k < 4; k++) check("pad_fcs", 32'(txq[base + 68 + k]), 32'({2'b10, fcs[8*k +: 8]}));
    check("pad_sent", sent1, STATS);
    // underrun while byte 5 is held
    base = txq.size();
    er0 = er_cnt;
    for (int i = 0; i < 6; i++) send_byte(8'(32'h10 + i), i == 0, 1'b0);
    fv = 1'b0;
    wait_idle(gap);
    check("urun_en_cycles", txq.size() - base, 32'd15);
    check("urun_byte5", 32'(txq[base + 13]), 32'h215);
    check("urun_abort", 32'(txq[base + 14]), 32'h300);
    check("urun_er", er_cnt - er0, 32'd1);
    check("urun_gap", gap, 32'd12);
    check("urun_aborted", ab1, STATS);
    check("urun_sent", sent1, STATS);
    check("urun_ready", 32'(rdy1), 32'h1);
    // link loss during PAD
    base = txq.size();
    er0 = er_cnt;
    send_byte(8'hC3, 1'b1, 1'b1);
    fv = 1'b0;
    repeat (12) tick();
    link_up = 1'b0;
    wait_idle(gap);
    check("link_en_cycles", txq.size() - base, 32'd14);
    check("link_abort", 32'(txq[base + 13]), 32'h300);
    check("link_er", er_cnt - er0, 32'd1);
    check("link_gap", gap, 32'd12);
    repeat (4) tick();
    check("link_gate", 32'(rdy1), 32'h0);
    check("link_busy", 32'(busy1), 32'h0);
    link_up = 1'b1;
    tick();
    check("link_ready", 32'(rdy1), 32'h1);
    check("link_aborted", ab1, STATS * 2);
    // back-to-back start offered during IPG
    base = txq.size();
    send_byte(8'h01, 1'b1, 1'b1);
    fv = 1'b0;
    t = 0;
    while (bus[9] && t < 200) begin
      tick();
      t++;
    end
    check("b2b_ipg_busy", 32'(busy1), 32'h1);
    fv = 1'b1; fd = 8'h02; fs = 1'b1; fl = 1'b1;
    t = 0;
    while (!rdy && t < 50) begin
      tick();
      t++;
    end
    check("b2b_hold_cycles", t, 32'd12);
    check("b2b_idle_bus", 32'(bus1), 32'h0);
    tick();
    fv = 1'b0;
    check("b2b_first_55", 32'(bus1), 32'h255);
    wait_idle(gap);
    check("b2b_en_cycles", txq.size() - base, 32'd144);
    check("b2b_gap", gap, 32'd12);
    // stray byte without start is consumed silently
    base = txq.size();
    send_byte(8'h77, 1'b0, 1'b0);
    fv = 1'b0;
    repeat (3) tick();
    check("stray_en", txq.size() - base, 32'd0);
    check("stray_busy", 32'(busy1), 32'h0);
    check("stray_ready", 32'(rdy1), 32'h1);
    check("b2b_sent", sent1, STATS * 3);
    // asynchronous reset in the middle of DATA
    for (int i = 0; i < 4; i++) send_byte(8'(32'hA0 + i), i == 0, 1'b0);
    check("mid_en", 32'(bus1[9]), 32'h1);
    fv = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_bus", 32'(bus1), 32'h0);
    check("arst_busy", 32'(busy1), 32'h0);
    check("arst_ready", 32'(rdy1), 32'h0);
    check("arst_sent", sent1, 32'h0);
    check("arst_aborted", ab1, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(rdy1), 32'h1);
    base = txq.size();
    er0 = er_cnt;
    send_byte(8'hDE, 1'b1, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b1);
    fv = 1'b0;
    wait_idle(gap);
    check("post_en_cycles", txq.size() - base, 32'd72);
    check("post_er", er_cnt - er0, 32'd0);
    check("post_gap", gap, 32'd12);
    check("post_byte0", 32'(txq[base + 8]), 32'h2DE);
    check("post_byte1", 32'(txq[base + 9]), 32'h2AD);
    frm = {8'hDE, 8'hAD};
    for (int i = 0; i < 58; i++) frm.push_back(8'h00);
    fcs = crc_model(frm);
    for (int k = 0; k < 4; k++) check("post_fcs", 32'(txq[base + 68 + k]), 32'({2'b10, fcs[8*k +: 8]}));
    check("post_sent", sent1, STATS);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
